// File: rtl/demux_pkg.sv
// demux_pkg: channel index constants, channel count and default widths for demux_14_buf
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int DEF_DW = 4;
  localparam int DEF_CW = 8;
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry buffer (clk, rst, load/d in, drain in, full/q out) that reloads on same-cycle drain+load
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] d,
  output logic          full,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else begin
      if (load) q <= d;
      full <= load | (full & ~drain);
    end
endmodule

// File: rtl/demux_14_buf.sv
// demux_14_buf: 1-to-4 buffered demux (in_data/in_valid/s1:s0 -> out_x/valid_x with ready_x), in_ready mux and saturating stall_cnt
module demux_14_buf
  import demux_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          s0,
  input  logic          s1,
  output logic          in_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [DW-1:0] out_c,
  output logic [DW-1:0] out_d,
  output logic          valid_a,
  output logic          valid_b,
  output logic          valid_c,
  output logic          valid_d,
  input  logic          ready_a,
  input  logic          ready_b,
  input  logic          ready_c,
  input  logic          ready_d,
  output logic [CW-1:0] stall_cnt
);
  logic [1:0]        sel;
  logic [NUM_CH-1:0] full, rdy, ld;
  logic [DW-1:0]     q [NUM_CH];
  assign sel      = {s1, s0};
  assign rdy      = {ready_d, ready_c, ready_b, ready_a};
  assign in_ready = ~full[sel] | rdy[sel];
  assign ld       = (in_valid & in_ready) ? NUM_CH'(1) << sel : '0;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.DW(DW)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (ld[i]),
      .drain(full[i] & rdy[i]),
      .d    (in_data),
      .full (full[i]),
      .q    (q[i])
    );
  end
  assign {valid_d, valid_c, valid_b, valid_a} = full;
  assign out_a = q[CH_A];
  assign out_b = q[CH_B];
  assign out_c = q[CH_C];
  assign out_d = q[CH_D];
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (in_valid & ~in_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_demux_14_buf.sv
// tb_demux_14_buf: directed self-checking bench for demux_14_buf
module tb_demux_14_buf;
  logic       clk, rst, in_valid, s0, s1, in_ready;
  logic [3:0] in_data, out_a, out_b, out_c, out_d;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic       ready_a, ready_b, ready_c, ready_d;
  logic [7:0] stall_cnt;
  int n_vec = 0;
  int n_err = 0;
  demux_14_buf #(.DW(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .s0(s0), .s1(s1),
    .in_ready(in_ready), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
    .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
    .stall_cnt(stall_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
    in_valid = v;
    {s1, s0} = s;
    in_data  = d;
  endtask
  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'h0);
    {ready_d, ready_c, ready_b, ready_a} = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_valid", {valid_d, valid_c, valid_b, valid_a}, 4'b0000);
    check("rst_out", {out_d, out_c, out_b, out_a}, 16'h0000);
    check("rst_stall", stall_cnt, 8'd0);
    for (int i = 0; i < 4; i++) begin
      {s1, s0} = i[1:0];
      #1 check("rst_in_ready", in_ready, 1'b1);
    end
    rst = 1'b0;
    drive(1'b1, 2'd2, 4'hA);
    @(negedge clk);
    in_valid = 1'b0;
    check("c_valid", {valid_d, valid_c, valid_b, valid_a}, 4'b0100);
    check("c_out", out_c, 4'hA);
    drive(1'b1, 2'd1, 4'h3);
    @(negedge clk);
    check("b_fill", {valid_b, out_b}, {1'b1, 4'h3});
    drive(1'b1, 2'd1, 4'h5);
    #1 check("b_stall_ready", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("b_hold", out_b, 4'h3);
    check("b_stall_cnt", stall_cnt, 8'd3);
    drive(1'b1, 2'd3, 4'h1);
    @(negedge clk);
    check("d_fill", {valid_d, out_d}, {1'b1, 4'h1});
    ready_d = 1'b1;
    drive(1'b1, 2'd3, 4'h7);
    #1 check("d_thru_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    ready_d  = 1'b0;
    check("d_thru", {valid_d, out_d}, {1'b1, 4'h7});
    ready_c = 1'b1;
    drive(1'b1, 2'd0, 4'h9);
    @(negedge clk);
    in_valid = 1'b0;
    check("a_acc_c_drain_valid", {valid_d, valid_c, valid_b, valid_a}, 4'b1011);
    check("a_acc_out", {out_d, out_c, out_b, out_a}, 16'h7A39);
    drive(1'b0, 2'd2, 4'hF);
    @(negedge clk);
    ready_c = 1'b0;
    check("no_load_c", {valid_c, out_c}, {1'b0, 4'hA});
    check("stall_kept", stall_cnt, 8'd3);
    drive(1'b1, 2'd1, 4'h5);
    repeat (100) @(negedge clk);
    check("stall_103", stall_cnt, 8'd103);
    repeat (200) @(negedge clk);
    check("stall_sat", stall_cnt, 8'd255);
    @(negedge clk);
    check("stall_sat_hold", stall_cnt, 8'd255);
    check("b_unchanged", out_b, 4'h3);
    drive(1'b1, 2'd2, 4'hC);
    @(negedge clk);
    in_valid = 1'b0;
    check("all_full", {valid_d, valid_c, valid_b, valid_a}, 4'b1111);
    #2 rst = 1'b1;
    #1 check("arst_valid", {valid_d, valid_c, valid_b, valid_a}, 4'b0000);
    check("arst_out", {out_d, out_c, out_b, out_a}, 16'h0000);
    check("arst_stall", stall_cnt, 8'd0);
    for (int i = 0; i < 4; i++) begin
      {s1, s0} = i[1:0];
      #1 check("arst_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'd0, 4'h5);
    #1 check("post_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_accept", {valid_d, valid_c, valid_b, valid_a, out_a}, {4'b0001, 4'h5});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
